stopwatch_bcd_lap: RTL and testbench
====================================

Name: stopwatch_bcd_lap

Overview:
- Parametrised next-generation stopwatch: single clock domain, no derived clocks.
- Counts minutes, seconds and hundredths directly in cascaded BCD digits, so no binary-to-BCD conversion is needed.
- Adds start/pause/resume, clear, overflow handling, a quick (accelerated) mode and optional lap capture.
- Sits between the debounced button block and the 7-segment display mux.

Parameters:
CLK_HZ, 100000000, input clock frequency
TICK_HZ, 100, count rate of the least-significant digit pair (hundredths)
QUICK_MUL, 100, speed-up factor while quick=1; CLK_HZ/TICK_HZ must be divisible by it
MIN_MAX, 99, highest minute value (BCD-displayable, ≤99)
WRAP, 0, 1 = roll over to 00:00.00 at terminal count; 0 = saturate and flag overflow

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start_stop  in  1  debounced level; each rising edge toggles run/pause
clear  in  1  debounced level; rising edge zeroes the time
lap  in  1  debounced level; rising edge captures lap (LAP_EN only)
quick  in  1  level; divider runs QUICK_MUL times faster
min_10, min_1, sec_10, sec_1, cs_10, cs_1  out  4 each  displayed BCD digits
running  out  1  high in RUN state
overflow  out  1  sticky terminal-count flag (WRAP=0)
lap_active  out  1  display is showing frozen lap value

Behaviour:
- reset_n low, asynchronous: all digits 0; state IDLE; prescaler 0; running=0; overflow=0; lap_active=0; edge-detect registers 0.
- Edge detection: each control input is registered once. An edge is in_now & ~in_prev, so the action takes effect on the clock edge after the input rises.
- Prescaler:
  - Terminal value DIV = CLK_HZ/TICK_HZ-1, or CLK_HZ/(TICK_HZ*QUICK_MUL)-1 while quick=1.
  - Counts only in RUN. At terminal it wraps to 0 and asserts an internal tick for one cycle.
  - If quick changes while the count is above the new terminal, the prescaler wraps at the next cycle; no extra tick is generated.
- Digit cascade, on tick:
  - cs_1 increments 0..9; a carry from it increments cs_10 0..9.
  - A carry from cs_10 increments sec_1 0..9, then sec_10 0..5.
  - A carry from sec_10 increments minutes as a BCD pair 00..MIN_MAX.
  - All digits update on the same clock edge as the tick. Latency from the prescaler terminal to the visible digit is 0 cycles, because the outputs are the registers.
- Terminal count is MIN_MAX:59.99. On the next tick:
  - WRAP=1: all digits go to 0 and counting continues.
  - WRAP=0: digits hold; overflow=1; state OVF.
- State machine:
  - IDLE --start_stop edge--> RUN
  - RUN --start_stop edge--> PAUSE
  - PAUSE --start_stop edge--> RUN
  - RUN --terminal tick, WRAP=0--> OVF
  - OVF ignores start_stop.
  - From any state, a clear edge goes to IDLE: digits 0, prescaler 0, overflow 0, lap_active 0.
- Pause: the prescaler value is retained, so resuming loses no partial tick.
- Simultaneous edges:
  - clear beats start_stop and lap.
  - start_stop in the same cycle as a tick: the tick is applied first, then the state changes.
  - lap in the same cycle as a tick captures the post-increment value.
- running is registered from the state: 1 exactly in RUN.

Optional Feature:
LAP_EN defined:
- Adds a 24-bit lap register.
- A lap edge in RUN copies the live digits into the lap register, sets lap_active=1, and the outputs show the lap register while counting continues internally.
- A lap edge while lap_active=1 (RUN or PAUSE) releases the freeze: lap_active=0 and the outputs show the live digits.
- A lap edge in IDLE or OVF is ignored.
- clear releases the freeze.

LAP_EN undefined:
- No lap register; the lap input is ignored.
- lap_active is tied to 0; the outputs always show the live digits.

Test Plan:
- Bench params: CLK_HZ=1000, TICK_HZ=100 (DIV=9), QUICK_MUL=2.
- Release reset; start_stop edge; run 100 clk -> digits 00:00.10, running=1.
- Pause after 45 clk in RUN (4 ticks, prescaler=5); hold 50 clk; resume -> cs_1=5 exactly 5 clk after the resume edge takes effect.
- quick=1 from 00:00.00, 50 clk in RUN -> 00:00.10 (DIV=4).
- MIN_MAX=1, WRAP=0, run past 01:59.99 -> holds 01:59.99, overflow=1, running=0, start_stop ignored. Then clear -> 00:00.00, IDLE, overflow=0.
- WRAP=1 with the same setup -> the tick after 01:59.99 gives 00:00.00, running stays 1.
- LAP_EN: lap edge at 00:00.37 -> outputs freeze at 00:00.37, lap_active=1; after 100 clk, lap edge again -> outputs 00:00.47. clear and start_stop rising in the same cycle -> IDLE, zeros.
- Assert reset_n low mid-RUN, asynchronously between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_bcd_lap.sv
// stopwatch_bcd_lap: BCD stopwatch (MM:SS.cc) with start/pause/resume, clear, overflow
// handling, accelerated "quick" mode and optional lap freeze.
//
// Optional feature macro: LAP_EN (defined = lap capture/freeze; undefined = lap ignored).
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   start_stop   debounced level, rising edge toggles run/pause
//   clear        debounced level, rising edge zeroes the time and returns to idle
//   lap          debounced level, rising edge captures/releases lap (LAP_EN only)
//   quick        level, prescaler terminal divided by QUICK_MUL
//   min_10..cs_1 displayed BCD digits
//   running      high in RUN state
//   overflow     sticky terminal-count flag (WRAP=0)
//   lap_active   display is showing the frozen lap value
module stopwatch_bcd_lap #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned QUICK_MUL = 100,
  parameter int unsigned MIN_MAX   = 99,
  parameter int unsigned WRAP      = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  input  logic       quick,
  output logic [3:0] min_10,
  output logic [3:0] min_1,
  output logic [3:0] sec_10,
  output logic [3:0] sec_1,
  output logic [3:0] cs_10,
  output logic [3:0] cs_1,
  output logic       running,
  output logic       overflow,
  output logic       lap_active
);

  localparam int unsigned DivN = CLK_HZ / TICK_HZ - 1;
  localparam int unsigned DivQ = CLK_HZ / (TICK_HZ * QUICK_MUL) - 1;
  localparam int unsigned PW   = (DivN > 0) ? $clog2(DivN + 1) : 1;

  localparam logic [PW-1:0] DivNV    = DivN[PW-1:0];
  localparam logic [PW-1:0] DivQV    = DivQ[PW-1:0];
  localparam logic [3:0]    MinTens  = 4'(MIN_MAX / 10);
  localparam logic [3:0]    MinOnes  = 4'(MIN_MAX % 10);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StOvf} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    min_10_q, min_10_d, min_1_q, min_1_d;
  logic [3:0]    sec_10_q, sec_10_d, sec_1_q, sec_1_d;
  logic [3:0]    cs_10_q, cs_10_d, cs_1_q, cs_1_d;
  logic          running_q, running_d;
  logic          overflow_q, overflow_d;
  logic          ss_prev_q, clr_prev_q;

  logic          ss_edge, clr_edge, tick, terminal;
  logic [PW-1:0] div_term;
  logic [23:0]   live;

  assign ss_edge  = start_stop & ~ss_prev_q;
  assign clr_edge = clear & ~clr_prev_q;
  assign div_term = quick ? DivQV : DivNV;
  assign live     = {min_10_q, min_1_q, sec_10_q, sec_1_q, cs_10_q, cs_1_q};
  assign terminal = (min_10_q == MinTens) && (min_1_q == MinOnes) && (sec_10_q == 4'd5) &&
                    (sec_1_q == 4'd9) && (cs_10_q == 4'd9) && (cs_1_q == 4'd9);

`ifdef LAP_EN
  logic        lap_prev_q;
  logic        lap_active_q, lap_active_d;
  logic [23:0] lap_val_q, lap_val_d;
  logic        lap_edge;

  assign lap_edge = lap & ~lap_prev_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
`endif

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    min_10_d   = min_10_q;
    min_1_d    = min_1_q;
    sec_10_d   = sec_10_q;
    sec_1_d    = sec_1_q;
    cs_10_d    = cs_10_q;
    cs_1_d     = cs_1_q;
    overflow_d = overflow_q;
    tick       = 1'b0;
`ifdef LAP_EN
    lap_active_d = lap_active_q;
    lap_val_d    = lap_val_q;
`endif

    // Prescaler; ">=" also catches a quick switch that leaves the count above the new terminal.
    if (state_q == StRun) begin
      if (presc_q >= div_term) begin
        presc_d = '0;
        tick    = (presc_q == div_term);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (tick) begin
      if (terminal) begin
        if (WRAP != 0) begin
          {min_10_d, min_1_d, sec_10_d, sec_1_d, cs_10_d, cs_1_d} = '0;
        end else begin
          overflow_d = 1'b1;
          state_d    = StOvf;
        end
      end else if (cs_1_q != 4'd9) begin
        cs_1_d = cs_1_q + 4'd1;
      end else begin
        cs_1_d = 4'd0;
        if (cs_10_q != 4'd9) begin
          cs_10_d = cs_10_q + 4'd1;
        end else begin
          cs_10_d = 4'd0;
          if (sec_1_q != 4'd9) begin
            sec_1_d = sec_1_q + 4'd1;
          end else begin
            sec_1_d = 4'd0;
            if (sec_10_q != 4'd5) begin
              sec_10_d = sec_10_q + 4'd1;
            end else begin
              sec_10_d = 4'd0;
              if (min_1_q != 4'd9) begin
                min_1_d = min_1_q + 4'd1;
              end else begin
                min_1_d  = 4'd0;
                min_10_d = min_10_q + 4'd1;
              end
            end
          end
        end
      end
    end

    // Tick has already been applied; a terminal tick into OVF wins over a pause request.
    if (ss_edge) begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   if (state_d != StOvf) state_d = StPause;
        StPause: state_d = StRun;
        default: ;
      endcase
    end

`ifdef LAP_EN
    if (lap_edge) begin
      if (lap_active_q && (state_q == StRun || state_q == StPause)) begin
        lap_active_d = 1'b0;
      end else if (!lap_active_q && state_q == StRun) begin
        lap_val_d    = {min_10_d, min_1_d, sec_10_d, sec_1_d, cs_10_d, cs_1_d};
        lap_active_d = 1'b1;
      end
    end
`endif

    if (clr_edge) begin
      state_d    = StIdle;
      presc_d    = '0;
      overflow_d = 1'b0;
      {min_10_d, min_1_d, sec_10_d, sec_1_d, cs_10_d, cs_1_d} = '0;
`ifdef LAP_EN
      lap_active_d = 1'b0;
`endif
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      min_10_q   <= '0;
      min_1_q    <= '0;
      sec_10_q   <= '0;
      sec_1_q    <= '0;
      cs_10_q    <= '0;
      cs_1_q     <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
      ss_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      min_10_q   <= min_10_d;
      min_1_q    <= min_1_d;
      sec_10_q   <= sec_10_d;
      sec_1_q    <= sec_1_d;
      cs_10_q    <= cs_10_d;
      cs_1_q     <= cs_1_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
      ss_prev_q  <= start_stop;
      clr_prev_q <= clear;
    end
  end

`ifdef LAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_prev_q   <= 1'b0;
      lap_active_q <= 1'b0;
      lap_val_q    <= '0;
    end else begin
      lap_prev_q   <= lap;
      lap_active_q <= lap_active_d;
      lap_val_q    <= lap_val_d;
    end
  end

  assign {min_10, min_1, sec_10, sec_1, cs_10, cs_1} = lap_active_q ? lap_val_q : live;
  assign lap_active = lap_active_q;
`else
  assign {min_10, min_1, sec_10, sec_1, cs_10, cs_1} = live;
  assign lap_active = 1'b0;
`endif

  assign running  = running_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_bcd_lap.sv
// tb_stopwatch_bcd_lap: directed bench for stopwatch_bcd_lap.
// Main DUT: CLK_HZ=1000, TICK_HZ=100 (DIV=9), QUICK_MUL=2 (quick DIV=4), MIN_MAX=99.
// Two MIN_MAX=1 DUTs (WRAP=0 / WRAP=1) use QUICK_MUL=10 so quick=1 ticks every cycle.
module tb_stopwatch_bcd_lap;

  logic clk = 1'b0;
  logic reset_n;
  logic start_stop, clear, lap, quick;
  logic o_ss, o_clr, o_quick;

  logic [3:0] m10, m1, s10, s1, c10, c1;
  logic       running, overflow, lap_active;
  logic [3:0] a_m10, a_m1, a_s10, a_s1, a_c10, a_c1;
  logic       a_running, a_overflow, a_lap_active;
  logic [3:0] b_m10, b_m1, b_s10, b_s1, b_c10, b_c1;
  logic       b_running, b_overflow, b_lap_active;

  logic [23:0] disp, disp_a, disp_b;
  assign disp   = {m10, m1, s10, s1, c10, c1};
  assign disp_a = {a_m10, a_m1, a_s10, a_s1, a_c10, a_c1};
  assign disp_b = {b_m10, b_m1, b_s10, b_s1, b_c10, b_c1};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_bcd_lap #(
    .CLK_HZ(1000), .TICK_HZ(100), .QUICK_MUL(2), .MIN_MAX(99), .WRAP(0)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .clear(clear), .lap(lap),
    .quick(quick), .min_10(m10), .min_1(m1), .sec_10(s10), .sec_1(s1), .cs_10(c10),
    .cs_1(c1), .running(running), .overflow(overflow), .lap_active(lap_active)
  );

  stopwatch_bcd_lap #(
    .CLK_HZ(1000), .TICK_HZ(100), .QUICK_MUL(10), .MIN_MAX(1), .WRAP(0)
  ) u_sat (
    .clk(clk), .reset_n(reset_n), .start_stop(o_ss), .clear(o_clr), .lap(1'b0),
    .quick(o_quick), .min_10(a_m10), .min_1(a_m1), .sec_10(a_s10), .sec_1(a_s1),
    .cs_10(a_c10), .cs_1(a_c1), .running(a_running), .overflow(a_overflow),
    .lap_active(a_lap_active)
  );

  stopwatch_bcd_lap #(
    .CLK_HZ(1000), .TICK_HZ(100), .QUICK_MUL(10), .MIN_MAX(1), .WRAP(1)
  ) u_wrap (
    .clk(clk), .reset_n(reset_n), .start_stop(o_ss), .clear(o_clr), .lap(1'b0),
    .quick(o_quick), .min_10(b_m10), .min_1(b_m1), .sec_10(b_s10), .sec_1(b_s1),
    .cs_10(b_c10), .cs_1(b_c1), .running(b_running), .overflow(b_overflow),
    .lap_active(b_lap_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and sample 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; step(1); start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; step(1); lap = 1'b0;
  endtask

  task automatic pulse_o_ss();
    o_ss = 1'b1; step(1); o_ss = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0; quick = 1'b0;
    o_ss = 1'b0; o_clr = 1'b0; o_quick = 1'b0;

    #12;
    check("reset_digits", disp, 24'h000000);
    check("reset_running", running, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_lap_active", lap_active, 1'b0);
    reset_n = 1'b1;
    step(1);

    // Basic run: 100 clocks = 10 ticks.
    pulse_ss();
    check("start_running", running, 1'b1);
    step(100);
    check("run100_digits", disp, 24'h000010);
    check("run100_running", running, 1'b1);

    // Pause keeps the partial prescaler count.
    pulse_clr();
    check("clear_digits", disp, 24'h000000);
    check("clear_running", running, 1'b0);
    pulse_ss();
    step(44);
    check("prepause_digits", disp, 24'h000004);
    pulse_ss();
    check("pause_running", running, 1'b0);
    step(50);
    check("paused_hold", disp, 24'h000004);
    pulse_ss();
    check("resume_running", running, 1'b1);
    step(4);
    check("resume_4clk", disp, 24'h000004);
    step(1);
    check("resume_5clk", disp, 24'h000005);

    // Quick mode: DIV=4, 50 clocks = 10 ticks.
    quick = 1'b1;
    pulse_clr();
    pulse_ss();
    step(50);
    check("quick50_digits", disp, 24'h000010);
    quick = 1'b0;

    pulse_clr();
    pulse_ss();
    step(370);
    check("pre_lap_digits", disp, 24'h000037);
`ifdef LAP_EN
    pulse_lap();
    check("lap_freeze_digits", disp, 24'h000037);
    check("lap_freeze_active", lap_active, 1'b1);
    step(100);
    check("lap_still_frozen", disp, 24'h000037);
    pulse_lap();
    check("lap_release_digits", disp, 24'h000047);
    check("lap_release_active", lap_active, 1'b0);
    pulse_lap();
    check("lap_refreeze_active", lap_active, 1'b1);
`else
    pulse_lap();
    check("lap_ignored_active", lap_active, 1'b0);
    step(10);
    check("lap_ignored_digits", disp, 24'h000038);
`endif
    // clear beats start_stop in the same cycle.
    clear = 1'b1; start_stop = 1'b1;
    step(1);
    clear = 1'b0; start_stop = 1'b0;
    check("clr_ss_digits", disp, 24'h000000);
    check("clr_ss_running", running, 1'b0);
    check("clr_ss_lap_active", lap_active, 1'b0);
    step(2);
    check("clr_ss_idle_hold", disp, 24'h000000);

    // Asynchronous reset between clock edges.
    pulse_ss();
    step(25);
    check("prereset_digits", disp, 24'h000002);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_digits", disp, 24'h000000);
    check("async_reset_running", running, 1'b0);
    #2;
    reset_n = 1'b1;
    step(1);
    check("post_reset_idle", running, 1'b0);

    // Terminal count with MIN_MAX=1, one tick per clock.
    o_quick = 1'b1;
    step(1);
    pulse_o_ss();
    step(11999);
    check("sat_terminal_digits", disp_a, 24'h015999);
    check("sat_terminal_ovf", a_overflow, 1'b0);
    check("wrap_terminal_digits", disp_b, 24'h015999);
    step(1);
    check("sat_hold_digits", disp_a, 24'h015999);
    check("sat_overflow", a_overflow, 1'b1);
    check("sat_running", a_running, 1'b0);
    check("wrap_zero_digits", disp_b, 24'h000000);
    check("wrap_running", b_running, 1'b1);
    check("wrap_overflow", b_overflow, 1'b0);
    step(5);
    check("wrap_continue", disp_b, 24'h000005);
    check("sat_still_hold", disp_a, 24'h015999);
    pulse_o_ss();
    step(3);
    check("sat_ss_ignored_run", a_running, 1'b0);
    check("sat_ss_ignored_digits", disp_a, 24'h015999);
    o_clr = 1'b1; step(1); o_clr = 1'b0;
    check("sat_clear_digits", disp_a, 24'h000000);
    check("sat_clear_ovf", a_overflow, 1'b0);
    check("sat_clear_running", a_running, 1'b0);
    pulse_o_ss();
    check("sat_restart_running", a_running, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
